// File: rtl/id_stream_pkg.sv
// Shared types and helpers for the id_stream_ctrl sequencer.
// Holds the FSM state encoding, default separator and saturating increment.
package id_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      RUN,
      POST,
      DRAIN,
      REPORT
   } state_t;

   localparam logic [7:0] SEP_DEFAULT = 8'h20;

   // Increment that sticks at the all-ones value of a w-bit field.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input int unsigned w
   );
      logic [31:0] top;
      top = (w >= 32) ? 32'hffff_ffff
                      : ((32'd1 << w) - 32'd1);
      return (v == top) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/id_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// ovf pulses when an increment is lost at the all-ones value.
module id_sat_cnt
   import id_stream_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         ovf
);

   assign ovf = inc && !clr && (q == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= W'(sat_inc(32'(q), W));
      end
   end

endmodule

// File: rtl/id_stream_ctrl.sv
// Frame sequencer feeding id_fsm; counts identifier hits per frame.
// ID_STREAM_CTRL_MAXLEN_EN adds longest-identifier-run tracking on max_len.
module id_stream_ctrl
   import id_stream_pkg::*;
#(
   parameter int         CNT_W     = 16,
   parameter logic [7:0] SEP_CHAR  = SEP_DEFAULT,
   parameter int         FLUSH_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic [7:0]       fsm_char,
   input  logic             fsm_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_hits,
   output logic [CNT_W-1:0] res_bytes,
   output logic             res_ovf,
   output logic [CNT_W-1:0] max_len
);

   localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   state_t        state;
   logic [FW-1:0] fcnt;
   logic          prev_out;
   logic          act;
   logic          take;
   logic          clr;
   logic          rise;
   logic          flush_done;
   logic          hits_ovf;
   logic          bytes_ovf;
   logic          run_ovf;

   assign act        = (state == RUN) || (state == POST) || (state == DRAIN);
   assign take       = (state == RUN) && in_valid && in_ready;
   assign clr        = (state == REPORT) && res_ready;
   assign rise       = act && fsm_out && !prev_out;
   assign flush_done = (fcnt == FW'(FLUSH_CYC - 1));

   id_sat_cnt #(.W(CNT_W)) u_hits (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (rise),
      .q     (res_hits),
      .ovf   (hits_ovf)
   );

   id_sat_cnt #(.W(CNT_W)) u_bytes (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (take),
      .q     (res_bytes),
      .ovf   (bytes_ovf)
   );

`ifdef ID_STREAM_CTRL_MAXLEN_EN
   logic [CNT_W-1:0] run_q;
   logic [CNT_W-1:0] run_nxt;
   logic [CNT_W-1:0] max_q;
   logic             run_inc;

   assign run_inc = act && fsm_out;
   assign run_nxt = CNT_W'(sat_inc(32'(run_q), CNT_W));

   // Run restarts on every low cycle of the recognizer output.
   id_sat_cnt #(.W(CNT_W)) u_run (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr || !run_inc),
      .inc   (run_inc),
      .q     (run_q),
      .ovf   (run_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= '0;
      end else if (clr) begin
         max_q <= '0;
      end else if (run_inc && (run_nxt > max_q)) begin
         max_q <= run_nxt;
      end
   end

   assign max_len = max_q;
`else
   assign run_ovf = 1'b0;
   assign max_len = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fcnt      <= '0;
         in_ready  <= 1'b0;
         fsm_char  <= SEP_CHAR;
         res_valid <= 1'b0;
         prev_out  <= 1'b0;
         res_ovf   <= 1'b0;
      end else begin
         prev_out <= fsm_out;
         if (hits_ovf || bytes_ovf || run_ovf) begin
            res_ovf <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= PRE;
                  fcnt     <= '0;
                  fsm_char <= SEP_CHAR;
                  prev_out <= 1'b0;
               end
            end
            PRE: begin
               fcnt <= fcnt + 1'b1;
               if (flush_done) begin
                  state    <= RUN;
                  in_ready <= 1'b1;
               end
            end
            RUN: begin
               if (take) begin
                  fsm_char <= in_data;
                  if (in_last) begin
                     state    <= POST;
                     in_ready <= 1'b0;
                     fcnt     <= '0;
                  end
               end
            end
            POST: begin
               fsm_char <= SEP_CHAR;
               fcnt     <= fcnt + 1'b1;
               if (flush_done) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               state     <= REPORT;
               res_valid <= 1'b1;
            end
            REPORT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  res_ovf   <= 1'b0;
                  // Back-to-back frames skip IDLE.
                  if (in_valid) begin
                     state    <= PRE;
                     fcnt     <= '0;
                     fsm_char <= SEP_CHAR;
                     prev_out <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_id_stream_ctrl.sv
// Directed bench for id_stream_ctrl with a behavioural identifier recognizer.
// A CNT_W=4 copy runs in lockstep to exercise counter saturation.
module tb_id_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic [7:0]  fsm_char;
   logic        fsm_out;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_hits;
   logic [15:0] res_bytes;
   logic        res_ovf;
   logic [15:0] max_len;

   logic        s_in_ready;
   logic [7:0]  s_fsm_char;
   logic        s_res_valid;
   logic [3:0]  s_res_hits;
   logic [3:0]  s_res_bytes;
   logic        s_res_ovf;
   logic [3:0]  s_max_len;

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int last_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   id_stream_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .fsm_char  (fsm_char),
      .fsm_out   (fsm_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_hits  (res_hits),
      .res_bytes (res_bytes),
      .res_ovf   (res_ovf),
      .max_len   (max_len)
   );

   id_stream_ctrl #(.CNT_W(4)) dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (s_in_ready),
      .fsm_char  (s_fsm_char),
      .fsm_out   (fsm_out),
      .res_valid (s_res_valid),
      .res_ready (res_ready),
      .res_hits  (s_res_hits),
      .res_bytes (s_res_bytes),
      .res_ovf   (s_res_ovf),
      .max_len   (s_max_len)
   );

   function automatic bit is_alpha(input logic [7:0] c);
      return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a)
             || c == 8'h5f;
   endfunction

   function automatic bit is_digit(input logic [7:0] c);
      return c >= 8'h30 && c <= 8'h39;
   endfunction

   // Recognizer: out high while inside an identifier, one cycle after the char.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_out <= 1'b0;
      else fsm_out <= is_alpha(fsm_char) || (fsm_out && is_digit(fsm_char));
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit last);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("send_timeout", 32'(in_ready), 32'd1);
      end else begin
         @(negedge clk);
         last_cyc = cyc;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!res_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
   endtask

   task automatic ack();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic report(input string tag, input int h, input int b,
                         input bit o);
      wait_valid(tag);
      check({tag, "_hits"}, 32'(res_hits), 32'(h));
      check({tag, "_bytes"}, 32'(res_bytes), 32'(b));
      check({tag, "_ovf"}, 32'(res_ovf), 32'(o));
      ack();
   endtask

   initial begin
      bit ok;
      logic [15:0] h0;
      logic [15:0] b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_fsm_char", 32'(fsm_char), 32'h20);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_hits", 32'(res_hits), 32'd0);
      check("rst_max_len", 32'(max_len), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Partial frame killed by reset.
      send(8'h61, 1'b0);
      send(8'h62, 1'b0);
      send(8'h63, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_fsm_char", 32'(fsm_char), 32'h20);
      check("midrst_bytes", 32'(res_bytes), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (res_valid) ok = 1'b0;
      end
      check("midrst_no_report", 32'(ok), 32'd1);

      // Three identifiers plus result latency.
      send_str("ab c1 x");
      wait_valid("f1");
      check("f1_latency", 32'(cyc - last_cyc), 32'd3);
      check("f1_hits", 32'(res_hits), 32'd3);
      check("f1_bytes", 32'(res_bytes), 32'd7);
      check("f1_ovf", 32'(res_ovf), 32'd0);
      ack();

      // Gapped frame; in_last and res_ready on idle cycles are ignored.
      send(8'h61, 1'b0);
      in_last   = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      in_last   = 1'b0;
      res_ready = 1'b0;
      check("gap_hold_a", 32'(fsm_char), 32'h61);
      check("gap_ready", 32'(in_ready), 32'd1);
      send(8'h62, 1'b0);
      @(negedge clk);
      check("gap_hold_b", 32'(fsm_char), 32'h62);
      send(8'h63, 1'b0);
      @(negedge clk);
      send(8'h64, 1'b1);
      report("gap", 1, 4, 1'b0);

      // Held summary, then handshake straight into the next frame.
      send_str("x1");
      wait_valid("hold");
      h0 = res_hits;
      b0 = res_bytes;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!res_valid || in_ready || res_hits !== h0 || res_bytes !== b0)
            ok = 1'b0;
      end
      check("hold_stable", 32'(ok), 32'd1);
      check("hold_hits", 32'(res_hits), 32'd1);
      check("hold_bytes", 32'(res_bytes), 32'd2);
      in_valid  = 1'b1;
      in_data   = 8'h7a;
      in_last   = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("b2b_valid_drop", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("b2b_pre", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("b2b_run", 32'(in_ready), 32'd1);
      send(8'h7a, 1'b1);
      report("b2b", 1, 1, 1'b0);

      // Twenty bytes saturate the 4-bit copy only.
      for (int i = 0; i < 20; i++) send(8'h61, i == 19);
      wait_valid("sat");
      check("sat_bytes", 32'(res_bytes), 32'd20);
      check("sat_ovf", 32'(res_ovf), 32'd0);
      check("sat_s_valid", 32'(s_res_valid), 32'd1);
      check("sat_s_bytes", 32'(s_res_bytes), 32'd15);
      check("sat_s_ovf", 32'(s_res_ovf), 32'd1);
      check("sat_s_hits", 32'(s_res_hits), 32'd1);
      ack();
      check("sat_s_ovf_clr", 32'(s_res_ovf), 32'd0);

      // Identifier runs of length 2 and 5.
      send_str("ab abcde");
      wait_valid("ml");
      check("ml_hits", 32'(res_hits), 32'd2);
      check("ml_bytes", 32'(res_bytes), 32'd8);
`ifdef ID_STREAM_CTRL_MAXLEN_EN
      check("ml_max_len", 32'(max_len), 32'd5);
`else
      check("ml_max_len", 32'(max_len), 32'd0);
`endif
      ack();
      check("ml_clr_hits", 32'(res_hits), 32'd0);
      check("ml_clr_max", 32'(max_len), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/id_stream_ctrl.md
Name: id_stream_ctrl

Overview:
- Sequencer that feeds a byte stream, one frame at a time, into the `id_fsm` character recognizer.
- Flushes the recognizer with a separator character before each frame and after the last byte of the frame.
- Counts rising edges of the recognizer's `out` as identifier hits and reports a per-frame summary over a valid/ready handshake.
- Sits between the character source (UART/ROM reader) and the recognizer. `id_fsm` is instantiated beside it, not inside it.

Parameters:
- CNT_W, 16, width of the hit and byte counters.
- SEP_CHAR, 8'h20, byte driven to the recognizer during flush cycles.
- FLUSH_CYC, 2, number of separator cycles in each flush phase (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source byte valid.
- in_data  input  8  source byte.
- in_last  input  1  marks the final byte of the frame.
- in_ready  output  1  controller accepts the byte this cycle.
- fsm_char  output  8  registered byte to `id_fsm.char`.
- fsm_out  input  1  `id_fsm.out`; reflects `fsm_char` one cycle later.
- res_valid  output  1  frame summary valid.
- res_ready  input  1  consumer takes the summary.
- res_hits  output  CNT_W  identifier count for the frame.
- res_bytes  output  CNT_W  payload bytes accepted in the frame.
- res_ovf  output  1  a counter saturated during the frame.
- max_len  output  CNT_W  longest identifier run (optional feature).

Behaviour:
- Reset (async, rst_n=0) values:
  - State IDLE; in_ready=0; fsm_char=SEP_CHAR; res_valid=0.
  - All counters, res_*, and max_len = 0.
- States:
  - IDLE → PRE when in_valid=1 (byte not consumed).
  - PRE: drive SEP_CHAR for FLUSH_CYC cycles; in_ready=0 → RUN.
  - RUN: in_ready=1.
    - On handshake (in_valid & in_ready): fsm_char<=in_data at the edge; bytes++.
    - Handshake with in_last=1 → POST.
    - Idle cycles (in_valid=0) hold fsm_char; no count.
  - POST: drive SEP_CHAR for FLUSH_CYC cycles; in_ready=0 → DRAIN.
  - DRAIN: one cycle to sample the final fsm_out → REPORT.
  - REPORT: res_valid=1; res_* stable until res_ready=1.
    - On handshake: counters clear and go to IDLE.
    - If in_valid=1 at that edge, go to PRE directly.
- Hit detection:
  - Register prev_out each cycle.
  - During RUN, POST, and DRAIN, if fsm_out=1 and prev_out=0 then hits++.
  - prev_out clears on PRE entry, so no edge carries over from the previous frame.
- Counters saturate at all-ones and never wrap; saturation sets sticky res_ovf for the frame.
- Latency:
  - Byte accepted at edge N → its fsm_out is sampled at edge N+1.
  - res_valid rises exactly FLUSH_CYC+1 cycles after the last-byte handshake.
- Boundaries:
  - Zero-gap frames: a frame with a single byte and in_last=1 is legal.
  - in_last on an idle cycle (in_valid=0) is ignored.
  - res_ready while res_valid=0 is ignored.
  - Reset mid-frame: everything returns to reset values; the partial frame is discarded and no summary is issued.

Optional Feature:
- ID_STREAM_CTRL_MAXLEN_EN defined:
  - Track the run length of consecutive fsm_out=1 cycles in RUN/POST/DRAIN, with saturation.
  - max_len = longest run in the frame, latched into the summary and cleared with the counters.
- Undefined: max_len is tied to 0 and no run logic is synthesized.

Decomposition:
- Package id_stream_pkg holds:
  - the state enum: IDLE, PRE, RUN, POST, DRAIN, REPORT;
  - the default SEP_CHAR constant;
  - a saturating-increment function.
- One sub-module: id_sat_cnt, a saturating counter with clr/inc/ovf. It is instantiated for hits, bytes, and the optional run/max logic.

Test Plan:
- Reset mid-RUN after 3 bytes → in_ready=0, fsm_char=8'h20, res_valid never asserts; the next frame's counts start from 0.
- Frame "ab c1 x" ending with in_last, recognizer-modelled out pulses on 3 identifiers → res_hits=3, res_bytes=7, res_ovf=0; res_valid rises 3 cycles after the last handshake (FLUSH_CYC=2).
- in_valid toggling 1/0 every cycle within a 4-byte frame → fsm_char holds during gaps; res_bytes=4.
- res_ready held low for 10 cycles in REPORT → res_* stable and in_ready=0 throughout; the handshake with in_valid=1 goes straight to PRE.
- CNT_W=4, 20-byte frame → res_bytes=15, res_ovf=1.
- ID_STREAM_CTRL_MAXLEN_EN defined, identifiers of length 2 and 5 → max_len=5; when undefined, max_len=0.
